// File: rtl/pc_pkg.sv
// Shared definitions for the fetch path: default PC geometry and the
// fetch-sequencer state encoding. Also used by the PC-select mux and the
// instruction memory.
package pc_pkg;

    localparam int PC_WIDTH_DEF = 8;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_EXEC  = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_register_unit_if.sv
// Bus between the PC register unit, the PC-select mux and instruction memory.
// master = the surrounding pipeline and memory; slave = pc_register_unit.
//
// Handshake: mem_req is held high for as long as the unit waits for a fetch.
// A fetch completes on the rising edge where mem_req and mem_ack are both 1.
// mem_ack is ignored while mem_req is low. There is no timeout.
interface pc_register_unit_if
    import pc_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
);
    logic                escr_pc;
    logic [PC_WIDTH-1:0] pc_alvo;
    logic                stall;
    logic                mem_ack;
    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] pc;
    logic                mem_req;
    logic                pc_valid;
    logic                stack_erro;

    modport master (
        output escr_pc, pc_alvo, stall, mem_ack, push, pop,
        input  pc, mem_req, pc_valid, stack_erro
    );

    modport slave (
        input  escr_pc, pc_alvo, stall, mem_ack, push, pop,
        output pc, mem_req, pc_valid, stack_erro
    );
endinterface

// File: rtl/pc_stack.sv
// Return-address LIFO used for call/return when PC_STACK_EN is defined.
// DEPTH must be a power of two, at least 2. Push and pop requests that
// would overflow or underflow are ignored here; the caller flags the error.
module pc_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      cnt_q;
    logic [AW-1:0]    top_idx;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign top_idx = AW'(cnt_q - (AW+1)'(1));
    assign dout    = mem[top_idx];

    // Occupancy count; pop has priority over a simultaneous push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pop && !empty) begin
            cnt_q <= cnt_q - (AW+1)'(1);
        end else if (push && !full) begin
            cnt_q <= cnt_q + (AW+1)'(1);
        end
    end

    // Storage has no reset; only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (push && !pop && !full) begin
            mem[cnt_q[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/pc_register_unit.sv
// Program-counter register and fetch sequencer. Holds the PC, issues one
// instruction-memory request per instruction and pulses pc_valid when the
// fetched instruction executes. Optional return stack: PC_STACK_EN.
module pc_register_unit
    import pc_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int RESET_PC    = RESET_PC_DEF,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    pc_register_unit_if.slave bus,
    output pc_state_t         fsm_state
);
    pc_state_t           state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic                mem_req, pc_valid;

    assign pc_inc       = pc_q + PC_WIDTH'(1);
    assign bus.pc       = pc_q;
    assign bus.mem_req  = mem_req;
    assign bus.pc_valid = pc_valid;
    assign fsm_state    = state_q;

`ifdef PC_STACK_EN
    logic                exec_go, stk_push, stk_pop, stk_full, stk_empty, err_q;
    logic [PC_WIDTH-1:0] stk_top;

    assign exec_go  = (state_q == S_EXEC) && !bus.stall;
    assign stk_pop  = exec_go && bus.pop && !stk_empty;
    assign stk_push = exec_go && bus.push && bus.escr_pc && !bus.pop && !stk_full;

    pc_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Sticky error on pop from empty or call into a full stack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (exec_go && ((bus.pop && stk_empty) ||
                                 (bus.push && bus.escr_pc && !bus.pop && stk_full))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.stack_erro = err_q;
`else
    logic unused_stack_in;
    localparam int unused_stack_depth = STACK_DEPTH;

    assign unused_stack_in = bus.push ^ bus.pop;
    assign bus.stack_erro  = 1'b0;
`endif

    // State and PC registers; reset can land in any state, even mid-fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
            pc_q    <= PC_WIDTH'(RESET_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC and the request/valid outputs.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        mem_req  = 1'b0;
        pc_valid = 1'b0;
        case (state_q)
            S_RESET: state_d = S_REQ;
            S_REQ: begin
                mem_req = 1'b1;
                if (bus.mem_ack) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!bus.stall) begin
                    pc_valid = 1'b1;
                    state_d  = S_REQ;
`ifdef PC_STACK_EN
                    if (bus.pop) begin
                        pc_d = stk_empty ? pc_inc : stk_top;
                    end else if (bus.escr_pc) begin
                        pc_d = bus.pc_alvo;
                    end else begin
                        pc_d = pc_inc;
                    end
`else
                    if (bus.escr_pc) begin
                        pc_d = bus.pc_alvo;
                    end else begin
                        pc_d = pc_inc;
                    end
`endif
                end
            end
            default: state_d = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_pc_register_unit.sv
// Testbench for pc_register_unit: directed instruction tables, an async
// reset during a fetch, stack boundary sequences and randomized instruction
// streams compared with an instruction-level model. Honours PC_STACK_EN.
module tb_pc_register_unit;
    import pc_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;
`ifdef PC_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic      clk = 1'b0;
    logic      rst = 1'b1;
    pc_state_t fsm_state;

    always #5 clk = ~clk;

    pc_register_unit_if #(.PC_WIDTH(W)) bus ();

    pc_register_unit #(
        .PC_WIDTH    (W),
        .RESET_PC    (0),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_cur;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    logic [W-1:0] m_pc;
    logic         m_err;
    logic [W-1:0] m_stk[$];

    task automatic model_reset();
        m_pc  = '0;
        m_err = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_step(input logic escr, input logic [W-1:0] alvo,
                              input logic psh, input logic pp);
        if (STK && pp) begin
            if (m_stk.size() == 0) begin
                m_pc  = m_pc + 1'b1;
                m_err = 1'b1;
            end else begin
                m_pc = m_stk.pop_back();
            end
        end else if (escr) begin
            if (STK && psh) begin
                if (m_stk.size() == DEPTH) m_err = 1'b1;
                else m_stk.push_back(m_pc + 1'b1);
            end
            m_pc = alvo;
        end else begin
            m_pc = m_pc + 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic garbage();
        bus.escr_pc = 1'($urandom_range(0, 1));
        bus.pc_alvo = W'($urandom);
        bus.push    = 1'($urandom_range(0, 1));
        bus.pop     = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, ".rst_pc"},    bus.pc,         '0);
        check({tag, ".rst_req"},   bus.mem_req,    '0);
        check({tag, ".rst_valid"}, bus.pc_valid,   '0);
        check({tag, ".rst_err"},   bus.stack_erro, '0);
        check({tag, ".rst_state"}, W'(fsm_state),  W'(S_RESET));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ack = 1'b0;
        bus.stall   = 1'b0;
        garbage();
        #1;
        check({tag, ".idle_req"}, bus.mem_req, '0);
        @(posedge clk); #1;
        check({tag, ".req_state"}, W'(fsm_state), W'(S_REQ));
        exp_cur = '0;
        model_reset();
    endtask

    // One full instruction: fetch (with ack_wait idle cycles), stall_n held
    // execute cycles, then the execute cycle that applies the PC update.
    task automatic run_instr(input string tag, input int ack_wait, input int stall_n,
                             input logic escr, input logic [W-1:0] alvo,
                             input logic psh, input logic pp,
                             input logic [W-1:0] exp_pc, input logic exp_err);
        for (int k = 0; k < ack_wait; k++) begin
            bus.mem_ack = 1'b0;
            bus.stall   = 1'($urandom_range(0, 1));
            garbage();
            #1;
            check({tag, ".wait_req"},   bus.mem_req,  1'b1);
            check({tag, ".wait_valid"}, bus.pc_valid, 1'b0);
            check({tag, ".wait_pc"},    bus.pc,       exp_cur);
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b1;
        garbage();
        #1;
        check({tag, ".ack_req"},   bus.mem_req,  1'b1);
        check({tag, ".ack_valid"}, bus.pc_valid, 1'b0);
        check({tag, ".ack_pc"},    bus.pc,       exp_cur);
        @(posedge clk); #1;
        for (int k = 0; k < stall_n; k++) begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            bus.stall   = 1'b1;
            garbage();
            #1;
            check({tag, ".stall_valid"}, bus.pc_valid, 1'b0);
            check({tag, ".stall_req"},   bus.mem_req,  1'b0);
            check({tag, ".stall_pc"},    bus.pc,       exp_cur);
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'($urandom_range(0, 1));
        bus.stall   = 1'b0;
        bus.escr_pc = escr;
        bus.pc_alvo = alvo;
        bus.push    = psh;
        bus.pop     = pp;
        #1;
        check({tag, ".exec_valid"}, bus.pc_valid, 1'b1);
        check({tag, ".exec_req"},   bus.mem_req,  1'b0);
        @(posedge clk); #1;
        garbage();
        bus.mem_ack = 1'b0;
        #1;
        check({tag, ".next_pc"},  bus.pc,         exp_pc);
        check({tag, ".next_err"}, bus.stack_erro, W'(exp_err));
        check({tag, ".next_req"}, bus.mem_req,    1'b1);
        exp_cur = exp_pc;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int           ack_wait;
        int           stall_n;
        logic         escr;
        logic [W-1:0] alvo;
        logic         psh;
        logic         pp;
        logic [W-1:0] exp_pc;
        logic         exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            run_instr($sformatf("%s%0d", tag, i), tbl[i].ack_wait, tbl[i].stall_n,
                      tbl[i].escr, tbl[i].alvo, tbl[i].psh, tbl[i].pp,
                      tbl[i].exp_pc, tbl[i].exp_err);
        end
        tbl.delete();
    endtask

    initial begin
        bus.escr_pc = 1'b0;
        bus.pc_alvo = '0;
        bus.stall   = 1'b0;
        bus.mem_ack = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;

        // Sequential run, jump, wrap, memory wait, stall, call/return.
        do_reset("r0");
        tbl.push_back('{0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0});
        tbl.push_back('{0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0});
        tbl.push_back('{0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0});
        tbl.push_back('{0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0});
        tbl.push_back('{0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 1'b0});
        tbl.push_back('{1, 0, 1'b1, 8'h40, 1'b0, 1'b0, 8'h40, 1'b0});
        tbl.push_back('{0, 0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0});
        tbl.push_back('{0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{3, 0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0});
        tbl.push_back('{0, 4, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0});
        tbl.push_back('{0, 0, 1'b1, 8'h03, 1'b0, 1'b0, 8'h03, 1'b0});
        tbl.push_back('{0, 0, 1'b1, 8'h20, 1'b1, 1'b0, 8'h20, 1'b0});
        tbl.push_back('{0, 0, 1'b0, 8'h55, 1'b0, 1'b1, STK ? 8'h04 : 8'h21, 1'b0});
        run_table("a");

        // Asynchronous reset between edges while a fetch is pending.
        #2;
        do_reset("r1");

        // Pop on an empty stack.
        tbl.push_back('{0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, STK});
        run_table("b");

        // Overflow on the fifth call, then returns and corner cases.
        do_reset("r2");
        tbl.push_back('{0, 0, 1'b1, 8'h30, 1'b1, 1'b0, 8'h30, 1'b0});
        tbl.push_back('{0, 0, 1'b1, 8'h31, 1'b1, 1'b0, 8'h31, 1'b0});
        tbl.push_back('{0, 0, 1'b1, 8'h32, 1'b1, 1'b0, 8'h32, 1'b0});
        tbl.push_back('{0, 0, 1'b1, 8'h33, 1'b1, 1'b0, 8'h33, 1'b0});
        tbl.push_back('{0, 0, 1'b1, 8'h34, 1'b1, 1'b0, 8'h34, STK});
        tbl.push_back('{0, 0, 1'b1, 8'h77, 1'b0, 1'b1, STK ? 8'h33 : 8'h77, STK});
        tbl.push_back('{0, 0, 1'b1, 8'h50, 1'b1, 1'b1, STK ? 8'h32 : 8'h50, STK});
        tbl.push_back('{0, 0, 1'b0, 8'h00, 1'b0, 1'b1, STK ? 8'h31 : 8'h51, STK});
        tbl.push_back('{0, 0, 1'b0, 8'h00, 1'b0, 1'b1, STK ? 8'h01 : 8'h52, STK});
        tbl.push_back('{0, 0, 1'b0, 8'h99, 1'b1, 1'b0, STK ? 8'h02 : 8'h53, STK});
        tbl.push_back('{0, 0, 1'b1, 8'h80, 1'b0, 1'b0, 8'h80, STK});
        tbl.push_back('{0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h81, STK});
        run_table("c");

        // Randomized instruction stream against the model.
        do_reset("r3");
        for (int i = 0; i < 80; i++) begin
            int           aw, sn;
            logic         e, ps, pp;
            logic [W-1:0] al;
            aw = $urandom_range(0, 2);
            sn = $urandom_range(0, 2);
            e  = ($urandom_range(0, 1) == 1);
            al = W'($urandom);
            ps = ($urandom_range(0, 9) < 3);
            pp = ($urandom_range(0, 9) < 3);
            model_step(e, al, ps, pp);
            exp_q.push_back(m_pc);
            run_instr($sformatf("rnd%0d", i), aw, sn, e, al, ps, pp,
                      exp_q.pop_front(), m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_register_unit.md
Name: pc_register_unit

Overview:
- Program-counter register and fetch sequencer. It consumes the PC-write decision (escr_pc) and jump target produced by the PC-select mux, holds the current PC, and issues one instruction-memory request per instruction.
- Sits between the PC-select mux (upstream) and instruction memory (downstream). Its pc_valid pulse triggers decode and execute.

Parameters:
- PC_WIDTH, 8, width of PC and jump target in bits.
- RESET_PC, 0, PC value loaded on reset.
- STACK_DEPTH, 4, return-stack entries; used only with PC_STACK_EN, power of 2, ≥2.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- escr_pc  in  1  PC write from PC-select mux: 1 = load pc_alvo, 0 = increment.
- pc_alvo  in  PC_WIDTH  jump target address.
- stall  in  1  execute-stage hold; freezes PC in EXEC.
- mem_ack  in  1  instruction memory has accepted the request and returned the word.
- push  in  1  call: save return address (PC_STACK_EN only).
- pop  in  1  return: reload PC from stack (PC_STACK_EN only).
- pc  out  PC_WIDTH  current program counter.
- mem_req  out  1  fetch request to instruction memory for address pc.
- pc_valid  out  1  one-cycle pulse: instruction at pc is fetched and in execute.
- stack_erro  out  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset (asynchronous, any state, including mid-fetch):
  - pc = RESET_PC, state = S_RESET.
  - mem_req = 0, pc_valid = 0, stack_erro = 0, stack pointer = 0.
- FSM states: S_RESET, S_REQ, S_EXEC.
  - S_RESET: outputs idle. Unconditionally moves to S_REQ on the next edge after rst deasserts.
  - S_REQ: mem_req = 1, pc held, escr_pc/push/pop ignored.
    - mem_ack = 1 → S_EXEC.
    - Otherwise stays in S_REQ with no timeout.
  - S_EXEC: pc_valid = 1 in every S_EXEC cycle in which stall = 0.
    - stall = 1: pc, state and stack unchanged; pc_valid = 0.
    - stall = 0: pc updated per the rules below → S_REQ.
- PC update, S_EXEC with stall = 0, priority high to low:
  - pop (stack mode)
  - escr_pc = 1 → pc <= pc_alvo
  - else → pc <= pc + 1, modulo 2^PC_WIDTH; e.g. 8'hFF → 8'h00, no flag.
- Latency:
  - Fetch-to-execute = 1 cycle after mem_ack.
  - Minimum instruction period = 2 cycles (S_REQ with immediate ack, then S_EXEC).
- mem_ack outside S_REQ is ignored.
- escr_pc and pc_alvo are sampled only in S_EXEC with stall = 0. They need not be stable in other cycles.
- Simultaneous escr_pc and pop: pop wins.
- Simultaneous push and pop: treated as pop only; push is discarded.

Optional Feature:
- Macro: PC_STACK_EN.
- Defined: a STACK_DEPTH-entry LIFO of PC_WIDTH words is instantiated.
  - push with escr_pc = 1 in S_EXEC (stall = 0): store pc + 1 (wrapped), then pc <= pc_alvo.
  - pop: pc <= top entry, pointer decremented.
  - push when full: stack unchanged, jump still taken, stack_erro <= 1.
  - pop when empty: pc <= pc + 1, stack_erro <= 1.
  - stack_erro clears only on rst.
  - push without escr_pc is ignored.
- Not defined: push and pop are ignored, stack_erro is tied to 0, and no stack storage is generated. The port list is identical in both builds.

Decomposition:
- Shared package pc_pkg holds:
  - state encoding localparams: S_RESET = 2'd0, S_REQ = 2'd1, S_EXEC = 2'd2
  - default PC_WIDTH and RESET_PC constants, reused by the PC-select mux and instruction memory.
- Sub-module pc_stack (LIFO: push, pop, data in/out, full, empty) instantiated only under PC_STACK_EN.
- FSM and PC register remain in pc_register_unit.

Test Plan:
- Reset then sequential run: rst 1→0, mem_ack always 1, escr_pc = 0 → pc goes 0, 1, 2, 3; pc_valid pulses every 2nd cycle; mem_req high in each S_REQ cycle.
- Jump: in S_EXEC at pc = 8'h05, escr_pc = 1, pc_alvo = 8'h40 → next S_REQ has pc = 8'h40. Repeat with escr_pc toggling during S_REQ → no effect.
- Wrap and memory wait: pc = 8'hFF, escr_pc = 0 → pc = 8'h00. Then hold mem_ack = 0 for 3 cycles → mem_req stays 1, pc stays 8'h00, pc_valid = 0 until 1 cycle after ack.
- Stall and async reset: stall = 1 for 4 cycles in S_EXEC at pc = 8'h10 → pc stays 8'h10, pc_valid = 0. Assert rst mid-S_REQ (between clock edges) → pc = RESET_PC and mem_req = 0 immediately.
- PC_STACK_EN call/return: at pc = 8'h03, push + escr_pc, pc_alvo = 8'h20 → pc = 8'h20; later pop → pc = 8'h04.
- PC_STACK_EN boundaries: 5 pushes with depth 4 → stack_erro = 1 after the 5th, 5th jump still taken. After rst, pop on empty → pc + 1, stack_erro = 1. Without the macro, the same stimulus → stack_erro = 0 and only escr_pc acts.
